tap_prog_sequencer: RTL
=======================

Name: tap_prog_sequencer

Overview:
- Host-side transmitter for the tap/LUT programming streams used across the DSP chain (FIR taps, reverb taps, transfer-function LUT).
- Software loads coefficients into a local buffer through a simple write port, then issues a start command.
- The block streams the coefficients out over a valid/ready interface, then waits for the receiver's done flag and reports status.
- One instance drives one programming port.

Parameters:
- G_DWIDTH, 24, coefficient width; set to 16 for tap ports and 24 for LUT ports.
- G_DEPTH_LOG2, 10, log2 of the buffer depth; maximum taps = 2**G_DEPTH_LOG2.
- G_TIMEOUT_CYCLES, 65535, maximum cycles allowed in WAIT_DONE before an error is flagged.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  0 behaves as reset for the FSM and status; buffer contents are retained.
- wr_addr  in  G_DEPTH_LOG2  buffer write address.
- wr_data  in  G_DWIDTH  buffer write data.
- wr_en  in  1  buffer write strobe; ignored while busy=1.
- start  in  1  single-cycle load command.
- num_taps  in  G_DEPTH_LOG2+1  number of taps to send; sampled with start.
- busy  out  1  high from an accepted start until return to IDLE.
- load_done  out  1  sticky; set on successful completion; cleared by the next accepted start.
- load_error  out  1  sticky; set on failure; cleared by the next accepted start.
- prog_dout  out  G_DWIDTH  coefficient to the receiver.
- prog_dout_valid  out  1  coefficient valid.
- prog_dout_ready  in  1  receiver ready.
- prog_done  in  1  receiver reports that programming is complete.

Behaviour:
- Reset / enable=0 values: FSM=IDLE, busy=0, load_done=0, load_error=0, prog_dout_valid=0, prog_dout=0, all counters=0. The buffer is not cleared.
- Buffer: single-clock RAM, 1-cycle read latency. A write and a read in the same cycle never occur, because writes are blocked while busy.
- FSM states: IDLE, PREFETCH, STREAM, WAIT_DONE.
- IDLE:
  - start=1 and num_taps in 1..2**G_DEPTH_LOG2: latch num_taps, clear both status flags, busy=1, issue read of address 0, go to PREFETCH.
  - start=1 and num_taps=0 or num_taps > depth: load_error=1, load_done=0, stay in IDLE.
- PREFETCH: one cycle. Register RAM data into prog_dout, assert prog_dout_valid, issue next read, go to STREAM.
  - Latency: start sampled at edge N gives prog_dout_valid=1 after edge N+2.
- STREAM:
  - A handshake is valid&ready. Once prog_dout_valid rises, it and prog_dout hold stable until the handshake.
  - A 2-entry skid/prefetch path sustains 1 tap per cycle while ready stays high. Ready toggling must not drop, duplicate or reorder taps.
  - Taps are sent in address order 0..num_taps-1.
  - On the handshake of tap num_taps-1: prog_dout_valid=0 the next cycle, go to WAIT_DONE, timeout counter=0.
  - prog_done=1 seen before the last handshake: abort, prog_dout_valid=0, load_error=1, go to IDLE.
- WAIT_DONE:
  - prog_done=1: load_done=1, busy=0, go to IDLE.
  - Otherwise the counter increments. When the counter reaches G_TIMEOUT_CYCLES: load_error=1, busy=0, go to IDLE.
  - prog_done=1 on the same cycle as the timeout: success wins.
- start while busy=1: ignored, no status change.
- prog_done already high at start: this counts as early done and takes the STREAM abort path. A receiver must deassert done when it is reset or re-armed.
- Reset or enable=0 mid-stream: immediate return to IDLE with outputs at reset values. The receiver sees a truncated stream and must be reset by its owner.
- num_taps = 2**G_DEPTH_LOG2: full-buffer load; the address counter must not wrap early.

Test Plan:
- Write 0x000001..0x000005 to addr 0..4; start with num_taps=5; ready held 1 -> taps 1..5 on consecutive cycles with first valid at N+2; prog_done pulsed 3 cycles later -> load_done=1, busy=0, load_error=0.
- Same load with ready toggled 1,0,0,1,0,1,... -> exactly 1..5 in order, data stable while stalled, no extra valid cycles.
- num_taps=0, then num_taps=2**G_DEPTH_LOG2+1 -> load_error=1 after each, busy never set, no valid. Then num_taps=1024 with 1024 ramp values -> all 1024 sent, last=1023.
- G_TIMEOUT_CYCLES=16, prog_done never asserted -> load_error=1 exactly 16 cycles after the last handshake; a second start clears load_error.
- prog_done asserted after 3 of 5 taps -> abort, load_error=1, valid low next cycle. A start and a wr_en issued during busy are ignored: buffer unchanged, num_taps not re-latched.
- reset asserted mid-STREAM, and separately enable=0 mid-STREAM -> next cycle valid=0, busy=0, flags=0. A restart replays the buffer from addr 0 with its contents intact.

Source files
------------

// File: rtl/tap_prog_sequencer.sv
// tap_prog_sequencer
//   Host-side transmitter for one tap/LUT programming port. Software fills a
//   local coefficient buffer through the write port and then issues start.
//   The block streams taps 0..num_taps-1 over valid/ready. It then waits for
//   the receiver's done flag and reports the outcome on two sticky flags.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   enable           0 acts as reset for FSM/status (buffer retained)
//   wr_addr/wr_data  buffer write port, wr_en strobe (ignored while busy)
//   start            single-cycle load command, num_taps sampled with it
//   busy             accepted start .. return to IDLE
//   load_done        sticky success flag, cleared by next accepted start
//   load_error       sticky failure flag, cleared by next accepted start
//   prog_dout        coefficient to receiver, qualified by prog_dout_valid
//   prog_dout_ready  receiver ready
//   prog_done        receiver reports programming complete
//
// State table
//   IDLE      | waiting for start, flags hold last outcome
//   PREFETCH  | first buffer read in flight, nothing presented yet
//   STREAM    | presenting taps, buffer reads kept ahead of the output
//   WAIT_DONE | all taps sent, waiting for prog_done or timeout
module tap_prog_sequencer #(
  parameter int G_DWIDTH         = 24,
  parameter int G_DEPTH_LOG2     = 10,
  parameter int G_TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [G_DEPTH_LOG2-1:0] wr_addr,
  input  logic [G_DWIDTH-1:0]     wr_data,
  input  logic                    wr_en,
  input  logic                    start,
  input  logic [G_DEPTH_LOG2:0]   num_taps,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_error,
  output logic [G_DWIDTH-1:0]     prog_dout,
  output logic                    prog_dout_valid,
  input  logic                    prog_dout_ready,
  input  logic                    prog_done
);

  localparam int DEPTH = 1 << G_DEPTH_LOG2;
  localparam int CW    = G_DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(G_TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(G_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFETCH,
    S_STREAM,
    S_WAIT_DONE
  } state_t;

  state_t state;

  logic [G_DWIDTH-1:0] mem [DEPTH];
  logic [G_DWIDTH-1:0] ram_q;
  logic [G_DWIDTH-1:0] skid_data;
  logic                ram_vld;
  logic                skid_vld;
  logic [CW-1:0]       n_taps;
  logic [CW-1:0]       rd_cnt;
  logic [CW-1:0]       tx_cnt;
  logic [TW-1:0]       to_cnt;

  logic       hs;
  logic       last_hs;
  logic       out_free;
  logic       start_ok;
  logic       rd_issue;
  logic [1:0] occ_next;

  assign hs       = prog_dout_valid & prog_dout_ready;
  assign last_hs  = hs && ((tx_cnt + CW'(1)) == n_taps);
  assign out_free = !prog_dout_valid || hs;
  assign start_ok = (num_taps != '0) && (num_taps <= DEPTH_C);

  // Entries that will be held after this edge (output, skid, RAM register).
  // A new read is only issued if its data is guaranteed a slot even when the
  // receiver stalls, so the output + skid pair can never overflow.
  assign occ_next = {1'b0, prog_dout_valid} + {1'b0, skid_vld}
                  + {1'b0, ram_vld} - {1'b0, hs};

  assign rd_issue = ((state == S_PREFETCH) || (state == S_STREAM))
                  && (rd_cnt != n_taps) && (occ_next <= 2'd1);

  // Coefficient buffer: no reset so contents survive reset/enable=0.
  // Writes are blocked while busy, so they never collide with stream reads.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_issue) begin
      ram_q <= mem[rd_cnt[G_DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
      prog_dout       <= '0;
      prog_dout_valid <= 1'b0;
      skid_data       <= '0;
      skid_vld        <= 1'b0;
      ram_vld         <= 1'b0;
      n_taps          <= '0;
      rd_cnt          <= '0;
      tx_cnt          <= '0;
      to_cnt          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              n_taps     <= num_taps;
              rd_cnt     <= '0;
              tx_cnt     <= '0;
              to_cnt     <= '0;
              load_done  <= 1'b0;
              load_error <= 1'b0;
              busy       <= 1'b1;
              state      <= S_PREFETCH;
            end else begin
              load_error <= 1'b1;
              load_done  <= 1'b0;
            end
          end
        end

        S_PREFETCH, S_STREAM: begin
          if (last_hs) begin
            // A done arriving with the final handshake is treated as a
            // normal completion; WAIT_DONE will see it next cycle if held.
            prog_dout_valid <= 1'b0;
            skid_vld        <= 1'b0;
            ram_vld         <= 1'b0;
            tx_cnt          <= tx_cnt + CW'(1);
            to_cnt          <= '0;
            state           <= S_WAIT_DONE;
          end else if (prog_done) begin
            prog_dout_valid <= 1'b0;
            skid_vld        <= 1'b0;
            ram_vld         <= 1'b0;
            load_error      <= 1'b1;
            busy            <= 1'b0;
            state           <= S_IDLE;
          end else begin
            state   <= S_STREAM;
            ram_vld <= rd_issue;
            if (rd_issue) begin
              rd_cnt <= rd_cnt + CW'(1);
            end
            if (hs) begin
              tx_cnt <= tx_cnt + CW'(1);
            end
            // Oldest data always moves to the output first: skid, then RAM.
            if (out_free) begin
              if (skid_vld) begin
                prog_dout       <= skid_data;
                prog_dout_valid <= 1'b1;
                if (ram_vld) begin
                  skid_data <= ram_q;
                end else begin
                  skid_vld <= 1'b0;
                end
              end else if (ram_vld) begin
                prog_dout       <= ram_q;
                prog_dout_valid <= 1'b1;
              end else begin
                prog_dout_valid <= 1'b0;
              end
            end else if (ram_vld) begin
              skid_data <= ram_q;
              skid_vld  <= 1'b1;
            end
          end
        end

        S_WAIT_DONE: begin
          if (prog_done) begin
            load_done <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (to_cnt == TO_LAST) begin
            to_cnt     <= to_cnt + TW'(1);
            load_error <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
